// File: rtl/noc_pkg.sv
// Shared NoC definitions: default widths, protocol error codes and the packet
// descriptor layout used by the assembler and the packet serializer.
package noc_pkg;

  localparam int ADDR_W = 10;
  localparam int VC_W   = 3;
  localparam int CNT_W  = 16;
  localparam int NUM_VC = 8;

  localparam logic [1:0] ERR_NONE      = 2'd0;
  localparam logic [1:0] ERR_HEAD_BUSY = 2'd1;
  localparam logic [1:0] ERR_ORPHAN    = 2'd2;
  localparam logic [1:0] ERR_OVF       = 2'd3;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dest;
    logic [VC_W-1:0]   vc;
    logic [CNT_W-1:0]  num_flits;
  } pkt_desc_t;

endpackage

// File: rtl/vc_track.sv
// Per-virtual-channel packet tracker: IDLE/ACTIVE state, captured head fields
// and a saturating flit count. Reports descriptor emission and protocol errors.
module vc_track #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc,
  input  logic              head,
  input  logic              tail,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dest_in,
  output logic              emit,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  num_flits,
  output logic [ADDR_W-1:0] desc_src,
  output logic [ADDR_W-1:0] desc_dest
);
  import noc_pkg::*;

  typedef enum logic {IDLE, ACTIVE} vc_state_t;

  vc_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] src_q, dest_q;
  logic              capture;
  logic [CNT_W:0]    inc;

  // MSB flags that the increment was clipped at all-ones.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return {1'b1, c};
    return {1'b0, c + CNT_W'(1)};
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    emit      = 1'b0;
    err_code  = ERR_NONE;
    num_flits = cnt;
    desc_src  = src_q;
    desc_dest = dest_q;
    inc       = sat_inc(cnt);
    if (acc) begin
      if (head) begin
        // A head on a busy VC abandons the old packet and restarts from IDLE.
        if (state == ACTIVE) err_code = ERR_HEAD_BUSY;
        if (tail) begin
          emit      = 1'b1;
          num_flits = CNT_W'(1);
          desc_src  = src_in;
          desc_dest = dest_in;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          capture   = 1'b1;
          cnt_nxt   = CNT_W'(1);
          state_nxt = ACTIVE;
        end
      end else if (state == IDLE) begin
        err_code = ERR_ORPHAN;
      end else begin
        if (inc[CNT_W]) err_code = ERR_OVF;
        if (tail) begin
          emit      = 1'b1;
          num_flits = inc[CNT_W-1:0];
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = inc[CNT_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      src_q  <= src_in;
      dest_q <= dest_in;
    end
  end

endmodule

// File: rtl/packet_assembler.sv
// Flit-stream sink: tracks one packet per VC and presents rebuilt descriptors
// on a valid/ready output register, with a one-cycle protocol-error strobe.
module packet_assembler #(
  parameter int NUM_VC = 8,
  parameter int VC_W   = 3,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flit_valid,
  output logic              flit_ready,
  input  logic              flit_head,
  input  logic              flit_tail,
  input  logic [VC_W-1:0]   flit_vc,
  input  logic [ADDR_W-1:0] flit_src,
  input  logic [ADDR_W-1:0] flit_dest,
  output logic              pkt_valid,
  input  logic              pkt_ready,
  output logic [ADDR_W-1:0] pkt_src,
  output logic [ADDR_W-1:0] pkt_dest,
  output logic [VC_W-1:0]   pkt_vc,
  output logic [CNT_W-1:0]  pkt_num_flits,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [VC_W-1:0]   err_vc
);
  import noc_pkg::*;

  logic              accept_p0;
  logic              emit_p0;
  logic [1:0]        err_p0;
  logic [NUM_VC-1:0] emit_vec;
  logic [1:0]        err_vec   [NUM_VC];
  logic [CNT_W-1:0]  nf_vec    [NUM_VC];
  logic [ADDR_W-1:0] src_vec   [NUM_VC];
  logic [ADDR_W-1:0] dest_vec  [NUM_VC];

  assign flit_ready = !pkt_valid || pkt_ready;
  assign accept_p0  = flit_valid && flit_ready;

  // p0: per-VC tracking
  for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
    vc_track #(
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
    ) u_vc_track (
      .clk       (clk),
      .rst       (rst),
      .acc       (accept_p0 && (flit_vc == VC_W'(v))),
      .head      (flit_head),
      .tail      (flit_tail),
      .src_in    (flit_src),
      .dest_in   (flit_dest),
      .emit      (emit_vec[v]),
      .err_code  (err_vec[v]),
      .num_flits (nf_vec[v]),
      .desc_src  (src_vec[v]),
      .desc_dest (dest_vec[v])
    );
  end

  // Only the addressed VC can be active in a cycle, so flit_vc selects directly.
  assign emit_p0 = accept_p0 && emit_vec[flit_vc];
  assign err_p0  = err_vec[flit_vc];

  // p1: descriptor and error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_valid     <= 1'b0;
      pkt_src       <= '0;
      pkt_dest      <= '0;
      pkt_vc        <= '0;
      pkt_num_flits <= '0;
      err_valid     <= 1'b0;
      err_code      <= ERR_NONE;
      err_vc        <= '0;
    end else begin
      if (emit_p0) begin
        pkt_valid     <= 1'b1;
        pkt_src       <= src_vec[flit_vc];
        pkt_dest      <= dest_vec[flit_vc];
        pkt_vc        <= flit_vc;
        pkt_num_flits <= nf_vec[flit_vc];
      end else if (pkt_ready) begin
        pkt_valid <= 1'b0;
      end
      err_valid <= accept_p0 && (err_p0 != ERR_NONE);
      if (accept_p0 && (err_p0 != ERR_NONE)) begin
        err_code <= err_p0;
        err_vc   <= flit_vc;
      end
    end
  end

endmodule

// File: tb/tb_packet_assembler.sv
// Directed bench for packet_assembler: table-driven vectors plus hand-written
// overflow and reset-mid-packet sequences on a narrow-counter instance.
module tb_packet_assembler;

  localparam int VC_W   = 3;
  localparam int ADDR_W = 10;
  localparam int CNT_W  = 16;
  localparam int OVF_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              flit_valid, flit_head, flit_tail, pkt_ready;
  logic [VC_W-1:0]   flit_vc;
  logic [ADDR_W-1:0] flit_src, flit_dest;

  logic              flit_ready, pkt_valid, err_valid;
  logic [ADDR_W-1:0] pkt_src, pkt_dest;
  logic [VC_W-1:0]   pkt_vc, err_vc;
  logic [CNT_W-1:0]  pkt_num_flits;
  logic [1:0]        err_code;

  logic              o_flit_ready, o_pkt_valid, o_err_valid;
  logic [ADDR_W-1:0] o_pkt_src, o_pkt_dest;
  logic [VC_W-1:0]   o_pkt_vc, o_err_vc;
  logic [OVF_W-1:0]  o_pkt_num_flits;
  logic [1:0]        o_err_code;

  packet_assembler #(.NUM_VC(8), .VC_W(VC_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .flit_head(flit_head), .flit_tail(flit_tail), .flit_vc(flit_vc),
    .flit_src(flit_src), .flit_dest(flit_dest), .pkt_valid(pkt_valid),
    .pkt_ready(pkt_ready), .pkt_src(pkt_src), .pkt_dest(pkt_dest),
    .pkt_vc(pkt_vc), .pkt_num_flits(pkt_num_flits), .err_valid(err_valid),
    .err_code(err_code), .err_vc(err_vc)
  );

  packet_assembler #(.NUM_VC(8), .VC_W(VC_W), .ADDR_W(ADDR_W), .CNT_W(OVF_W)) u_ovf (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_ready(o_flit_ready),
    .flit_head(flit_head), .flit_tail(flit_tail), .flit_vc(flit_vc),
    .flit_src(flit_src), .flit_dest(flit_dest), .pkt_valid(o_pkt_valid),
    .pkt_ready(pkt_ready), .pkt_src(o_pkt_src), .pkt_dest(o_pkt_dest),
    .pkt_vc(o_pkt_vc), .pkt_num_flits(o_pkt_num_flits), .err_valid(o_err_valid),
    .err_code(o_err_code), .err_vc(o_err_vc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic              v, h, t;
    logic [VC_W-1:0]   vc;
    logic [ADDR_W-1:0] src, dest;
    logic              rdy;
    logic              fr;
    logic              pv;
    logic [ADDR_W-1:0] psrc, pdest;
    logic [VC_W-1:0]   pvc;
    logic [CNT_W-1:0]  pnf;
    logic              ev;
    logic [1:0]        ec;
    logic [VC_W-1:0]   evc;
  } vec_t;

  function automatic vec_t mk(input logic v, h, t, input int vc, src, dest,
                              input logic rdy, fr, pv, input int psrc, pdest, pvc, pnf,
                              input logic ev, input int ec, evc);
    vec_t r;
    r.v = v; r.h = h; r.t = t; r.vc = VC_W'(vc);
    r.src = ADDR_W'(src); r.dest = ADDR_W'(dest); r.rdy = rdy; r.fr = fr;
    r.pv = pv; r.psrc = ADDR_W'(psrc); r.pdest = ADDR_W'(pdest);
    r.pvc = VC_W'(pvc); r.pnf = CNT_W'(pnf);
    r.ev = ev; r.ec = 2'(ec); r.evc = VC_W'(evc);
    return r;
  endfunction

  task automatic drive(input logic v, h, t, input int vc, src, dest, input logic rdy);
    @(negedge clk);
    flit_valid = v; flit_head = h; flit_tail = t;
    flit_vc = VC_W'(vc); flit_src = ADDR_W'(src); flit_dest = ADDR_W'(dest);
    pkt_ready = rdy;
  endtask

  task automatic send(input logic v, h, t, input int vc, src, dest, input logic rdy);
    drive(v, h, t, vc, src, dest, rdy);
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [20];

  initial begin
    //                v  h  t  vc src dst rdy fr pv psrc pdst pvc pnf ev ec evc
    tbl[0]  = mk(1, 1, 1, 2,  5,  9, 1,  1, 1,  5,  9, 2, 1, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0,  1,  3, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 7,  8,  2, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 77, 77, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 0, 7, 77, 77, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 0, 0, 77, 77, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 7, 99, 99, 1,  1, 1,  8,  2, 7, 3, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1, 0, 99, 99, 1,  1, 1,  1,  3, 0, 4, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 0,  0,  0, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[9]  = mk(1, 0, 0, 4,  0,  0, 1,  1, 0,  0,  0, 0, 0, 1, 2, 4);
    tbl[10] = mk(1, 1, 0, 1, 20, 21, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 1, 30, 31, 1,  1, 0,  0,  0, 0, 0, 1, 1, 1);
    tbl[12] = mk(1, 0, 1, 1,  0,  0, 1,  1, 1, 30, 31, 1, 2, 0, 0, 0);
    tbl[13] = mk(0, 0, 0, 0,  0,  0, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[14] = mk(1, 1, 0, 5, 40, 41, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);
    tbl[15] = mk(1, 0, 1, 5,  0,  0, 0,  1, 1, 40, 41, 5, 2, 0, 0, 0);
    tbl[16] = mk(1, 1, 1, 6, 50, 51, 0,  0, 1, 40, 41, 5, 2, 0, 0, 0);
    tbl[17] = mk(1, 0, 0, 2,  0,  0, 0,  0, 1, 40, 41, 5, 2, 0, 0, 0);
    tbl[18] = mk(1, 1, 1, 6, 50, 51, 1,  1, 1, 50, 51, 6, 1, 0, 0, 0);
    tbl[19] = mk(0, 0, 0, 0,  0,  0, 1,  1, 0,  0,  0, 0, 0, 0, 0, 0);

    rst = 1'b1;
    flit_valid = 1'b0; flit_head = 1'b0; flit_tail = 1'b0;
    flit_vc = '0; flit_src = '0; flit_dest = '0; pkt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset pkt_valid", 32'(pkt_valid), 0);
    chk("reset err_valid", 32'(err_valid), 0);
    chk("reset pkt_src", 32'(pkt_src), 0);
    chk("reset pkt_num_flits", 32'(pkt_num_flits), 0);
    chk("reset flit_ready", 32'(flit_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].v, tbl[i].h, tbl[i].t, int'(tbl[i].vc), int'(tbl[i].src),
            int'(tbl[i].dest), tbl[i].rdy);
      #1;
      chk($sformatf("vec%0d flit_ready", i), 32'(flit_ready), 32'(tbl[i].fr));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pkt_valid", i), 32'(pkt_valid), 32'(tbl[i].pv));
      if (tbl[i].pv) begin
        chk($sformatf("vec%0d pkt_src", i), 32'(pkt_src), 32'(tbl[i].psrc));
        chk($sformatf("vec%0d pkt_dest", i), 32'(pkt_dest), 32'(tbl[i].pdest));
        chk($sformatf("vec%0d pkt_vc", i), 32'(pkt_vc), 32'(tbl[i].pvc));
        chk($sformatf("vec%0d pkt_num_flits", i), 32'(pkt_num_flits), 32'(tbl[i].pnf));
      end
      chk($sformatf("vec%0d err_valid", i), 32'(err_valid), 32'(tbl[i].ev));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d err_code", i), 32'(err_code), 32'(tbl[i].ec));
        chk($sformatf("vec%0d err_vc", i), 32'(err_vc), 32'(tbl[i].evc));
      end
    end

    // 17-flit packet on vc3 against the 4-bit counter instance.
    send(1, 1, 0, 3, 60, 61, 1);
    for (int f = 2; f <= 15; f++) send(1, 0, 0, 3, 0, 0, 1);
    chk("ovf flit15 no err", 32'(o_err_valid), 0);
    send(1, 0, 0, 3, 0, 0, 1);
    chk("ovf flit16 err_valid", 32'(o_err_valid), 1);
    chk("ovf flit16 err_code", 32'(o_err_code), 3);
    chk("ovf flit16 err_vc", 32'(o_err_vc), 3);
    chk("wide flit16 no err", 32'(err_valid), 0);
    send(1, 0, 1, 3, 0, 0, 1);
    chk("ovf tail err_code", 32'(o_err_code), 3);
    chk("ovf tail pkt_valid", 32'(o_pkt_valid), 1);
    chk("ovf tail num_flits", 32'(o_pkt_num_flits), 15);
    chk("ovf tail pkt_src", 32'(o_pkt_src), 60);
    chk("wide tail num_flits", 32'(pkt_num_flits), 17);
    send(0, 0, 0, 0, 0, 0, 1);
    chk("ovf idle err_valid", 32'(o_err_valid), 0);

    // Reset mid-packet on vc3 with a descriptor pending on the output.
    send(1, 1, 0, 3, 70, 71, 1);
    send(1, 0, 0, 3, 0, 0, 1);
    send(1, 1, 1, 6, 80, 81, 0);
    chk("pre-rst pkt_valid", 32'(pkt_valid), 1);
    @(negedge clk);
    rst = 1'b1; flit_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst pkt_valid", 32'(pkt_valid), 0);
    chk("rst pkt_dest", 32'(pkt_dest), 0);
    chk("rst pkt_vc", 32'(pkt_vc), 0);
    chk("rst pkt_num_flits", 32'(pkt_num_flits), 0);
    chk("rst err_code", 32'(o_err_code), 0);
    chk("rst err_vc", 32'(o_err_vc), 0);
    chk("rst ovf pkt_valid", 32'(o_pkt_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    send(1, 0, 0, 3, 0, 0, 1);
    chk("post-rst body err_valid", 32'(err_valid), 1);
    chk("post-rst body err_code", 32'(err_code), 2);
    chk("post-rst body err_vc", 32'(err_vc), 3);
    chk("post-rst body pkt_valid", 32'(pkt_valid), 0);
    send(1, 0, 1, 3, 0, 0, 1);
    chk("post-rst tail err_code", 32'(err_code), 2);
    chk("post-rst tail pkt_valid", 32'(pkt_valid), 0);
    send(0, 0, 0, 0, 0, 0, 1);
    chk("final err_valid", 32'(err_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
